// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and default parameter values shared by the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_CPU_OWN = 2'd0,
    ARB_DRAIN   = 2'd1,
    ARB_DMA_OWN = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;
  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_MAX_BURST    = 8;
  localparam int DEF_CPU_QUANTUM  = 16;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a halt-only core and a DMA master, granting bounded DMA bursts once the core is parked
// Ports: CLK/RST_N clock and async active-low reset; ext_halt external halt; cpu_* core side (cs, we, addr, wdata, rdata, halt);
// dma_* DMA side (req, we, addr, wdata, gnt, rdata, rvalid); mem_* memory side (cs, we, addr, wdata, rdata); err_conflict sticky core-access-during-DMA flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int CPU_QUANTUM  = DEF_CPU_QUANTUM
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ext_halt,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_halt,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_conflict
);
  localparam logic [7:0] D_N = DRAIN_CYCLES[7:0];
  localparam logic [7:0] B_N = MAX_BURST[7:0];
  localparam logic [7:0] Q_N = CPU_QUANTUM[7:0];
  arb_state_e state, state_n;
  logic [7:0] q_cnt, d_cnt, b_cnt, d_nxt, b_nxt;
  logic q_exp, expired, own;
  assign own = state == ARB_DMA_OWN;
  assign d_nxt = cpu_cs ? 8'd0 : d_cnt + 8'd1;
  assign b_nxt = b_cnt + 8'd1;
  // q_cnt counts finished CPU_OWN cycles, so the current cycle is the
  // (q_cnt+1)-th; q_exp covers the post-reset "already expired" case.
  assign expired = q_exp | (q_cnt >= Q_N - 8'd1);
  always_comb begin
    state_n = state;
    unique case (state)
      ARB_CPU_OWN: state_n = (dma_req && expired) ? ARB_DRAIN : ARB_CPU_OWN;
      ARB_DRAIN:   state_n = !dma_req ? ARB_RELEASE : (d_nxt == D_N) ? ARB_DMA_OWN : ARB_DRAIN;
      ARB_DMA_OWN: state_n = (!dma_req || b_nxt == B_N) ? ARB_RELEASE : ARB_DMA_OWN;
      ARB_RELEASE: state_n = ARB_CPU_OWN;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ARB_CPU_OWN;
      q_cnt        <= 8'd0;
      d_cnt        <= 8'd0;
      b_cnt        <= 8'd0;
      q_exp        <= 1'b1;
      err_conflict <= 1'b0;
    end else begin
      state        <= state_n;
      err_conflict <= err_conflict | (own & cpu_cs);
      q_exp        <= state == ARB_RELEASE ? 1'b0 : q_exp;
      q_cnt        <= state == ARB_RELEASE ? 8'd0 : (state == ARB_CPU_OWN && q_cnt != Q_N) ? q_cnt + 8'd1 : q_cnt;
      d_cnt        <= state == ARB_DRAIN ? d_nxt : state == ARB_RELEASE ? 8'd0 : d_cnt;
      b_cnt        <= (own && dma_req) ? b_nxt : state == ARB_RELEASE ? 8'd0 : b_cnt;
    end
  end
  assign cpu_halt   = ext_halt | own | (state == ARB_DRAIN);
  assign dma_gnt    = own;
  assign dma_rvalid = own & dma_req & !dma_we;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign mem_cs     = own ? dma_req : cpu_cs;
  assign mem_we     = own ? dma_req & dma_we : cpu_we;
  assign mem_addr   = own ? dma_addr : cpu_addr;
  assign mem_wdata  = own ? dma_wdata : cpu_wdata;
endmodule
